// File: rtl/rv32m_pkg.sv
// Shared constants and state encoding for the rv32m issue/writeback sequencer.
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rv32m_special_case.sv
// Divide-by-zero and signed-overflow results that the ISA defines as fixed values,
// so they never need the multicycle unit.
module rv32m_special_case
  import rv32m_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic div_zero;
  logic overflow;

  always_comb begin
    div_zero       = funct3[2] && (rs2 == '0);
    overflow       = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (rs1 == INT_MIN) && (rs2 == NEG_ONE);
    is_special     = div_zero || overflow;
    special_result = '0;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_result = funct3[1] ? rs1 : NEG_ONE;
    end else if (overflow) begin
      special_result = funct3[1] ? 32'h0 : INT_MIN;
    end
  end

endmodule

// File: rtl/rv32m_issue.sv
// Issue/writeback sequencer in front of the multicycle rv32m unit: decodes, resolves
// special cases locally, otherwise starts the unit and waits with a timeout.
module rv32m_issue
  import rv32m_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_instr,
  input  logic [XLEN-1:0] issue_rs1_val,
  input  logic [XLEN-1:0] issue_rs2_val,
  output logic [XLEN-1:0] mdu_rs1,
  output logic [XLEN-1:0] mdu_rs2,
  output logic [2:0]      mdu_funct3,
  output logic            mdu_in_valid,
  output logic            mdu_clr,
  input  logic [XLEN-1:0] mdu_rd,
  input  logic            mdu_out_valid,
  input  logic            mdu_in_error,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_error
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a valid, once raised, holds its payload stable until that transfer.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            clr_pulse;
  logic            legal;
  logic            is_special;
  logic [XLEN-1:0] special_result;
  logic            unused_bits;

  assign unused_bits = ^issue_instr[24:15];
  assign legal       = (issue_instr[6:0] == OPCODE_OP) && (issue_instr[31:25] == FUNCT7_MULDIV);
  assign issue_ready = (state == ST_IDLE) && rst;
  assign mdu_clr     = !rst || clr_pulse;

  rv32m_special_case u_special (
    .funct3         (issue_instr[14:12]),
    .rs1            (issue_rs1_val),
    .rs2            (issue_rs2_val),
    .is_special     (is_special),
    .special_result (special_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      clr_pulse    <= 1'b0;
      mdu_in_valid <= 1'b0;
      mdu_rs1      <= '0;
      mdu_rs2      <= '0;
      mdu_funct3   <= '0;
      wb_valid     <= 1'b0;
      wb_error     <= 1'b0;
      wb_data      <= '0;
      wb_rd_idx    <= '0;
    end else begin
      clr_pulse    <= 1'b0;
      mdu_in_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_valid) begin
            wb_rd_idx <= issue_instr[11:7];
            if (!legal) begin
              wb_data  <= '0;
              wb_error <= 1'b1;
              wb_valid <= 1'b1;
              state    <= ST_RESP;
            end else if (is_special) begin
              wb_data  <= special_result;
              wb_error <= 1'b0;
              wb_valid <= 1'b1;
              state    <= ST_RESP;
            end else begin
              mdu_rs1      <= issue_rs1_val;
              mdu_rs2      <= issue_rs2_val;
              mdu_funct3   <= issue_instr[14:12];
              mdu_in_valid <= 1'b1;
              state        <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A result arriving on the timeout cycle still wins.
          if (mdu_out_valid) begin
            wb_data  <= mdu_rd;
            wb_error <= mdu_in_error;
            wb_valid <= 1'b1;
            state    <= ST_RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            wb_data   <= '0;
            wb_error  <= 1'b1;
            wb_valid  <= 1'b1;
            clr_pulse <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_issue.sv
// Bench for rv32m_issue: directed scenarios plus randomized ops against a behavioural
// RV32M reference model; the bench itself plays the multicycle unit.
module tb_rv32m_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [31:0] issue_rs1_val;
  logic [31:0] issue_rs2_val;
  logic [31:0] mdu_rs1;
  logic [31:0] mdu_rs2;
  logic [2:0]  mdu_funct3;
  logic        mdu_in_valid;
  logic        mdu_clr;
  logic [31:0] mdu_rd;
  logic        mdu_out_valid;
  logic        mdu_in_error;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_data;
  logic        wb_error;

  int checks = 0;
  int failures = 0;
  int in_pulses = 0;
  int clr_pulses = 0;
  logic [31:0] exp_q[$];

  rv32m_issue #(.TIMEOUT(64), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2), .mdu_funct3(mdu_funct3),
    .mdu_in_valid(mdu_in_valid), .mdu_clr(mdu_clr), .mdu_rd(mdu_rd),
    .mdu_out_valid(mdu_out_valid), .mdu_in_error(mdu_in_error),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_idx(wb_rd_idx),
    .wb_data(wb_data), .wb_error(wb_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && mdu_in_valid) in_pulses++;
    if (rst && mdu_clr) clr_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
    logic [4:0] rs1i;
    logic [4:0] rs2i;
    rs1i = 5'($urandom_range(0, 31));
    rs2i = 5'($urandom_range(0, 31));
    return {f7, rs2i, rs1i, f3, rd, op};
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_local(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    bit signed_div;
    signed_div = (f3 == 3'd4) || (f3 == 3'd6);
    return (f3[2] && b == 0) || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 100));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic do_issue(input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, output bit ok);
    ok = 0;
    issue_instr = instr;
    issue_rs1_val = a;
    issue_rs2_val = b;
    issue_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (issue_ready) ok = 1;
      tick();
    end
    issue_valid = 1'b0;
  endtask

  // From the ISSUE cycle: plays the unit, answering lat cycles into WAIT.
  task automatic respond(input int lat, input logic [31:0] data, input logic err,
                         output int early);
    early = 0;
    tick();
    for (int i = 1; i < lat; i++) begin
      if (wb_valid !== 1'b0) early++;
      tick();
    end
    if (wb_valid !== 1'b0) early++;
    mdu_out_valid = 1'b1;
    mdu_rd = data;
    mdu_in_error = err;
    tick();
    mdu_out_valid = 1'b0;
    mdu_rd = $urandom;
    mdu_in_error = 1'b0;
  endtask

  task automatic release_wb();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (wb_valid !== 0 || wb_error !== 0 || wb_data !== 0 || wb_rd_idx !== 0) begin
      failures++;
      $display("FAIL reset_wb: got v=%b e=%b d=%h rd=%0d want all 0", wb_valid, wb_error, wb_data, wb_rd_idx);
    end
    checks++;
    if (mdu_in_valid !== 0 || mdu_rs1 !== 0 || mdu_rs2 !== 0 || mdu_funct3 !== 0) begin
      failures++;
      $display("FAIL reset_mdu: got iv=%b rs1=%h rs2=%h f3=%b want all 0", mdu_in_valid, mdu_rs1, mdu_rs2, mdu_funct3);
    end
    checks++;
    if (mdu_clr !== 1'b1 || issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_clr_ready: got clr=%b ready=%b want clr=1 ready=0", mdu_clr, issue_ready);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mdu_clr !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got clr=%b ready=%b want clr=0 ready=1", mdu_clr, issue_ready);
    end
  endtask

  task automatic test_mul();
    bit ok;
    int early;
    int p0;
    p0 = in_pulses;
    do_issue(32'h0262_82B3, 32'd7, 32'd6, ok);
    checks++;
    if (!ok || mdu_in_valid !== 1'b1 || mdu_funct3 !== 3'b000 || mdu_rs1 !== 7 || mdu_rs2 !== 6) begin
      failures++;
      $display("FAIL mul_issue: got ok=%0b iv=%b f3=%b rs1=%h rs2=%h want 1 1 000 7 6", ok, mdu_in_valid, mdu_funct3, mdu_rs1, mdu_rs2);
    end
    respond(10, 32'd42, 1'b0, early);
    checks++;
    if (early != 0 || wb_valid !== 1'b1 || wb_data !== 32'd42 || wb_rd_idx !== 5'd5 || wb_error !== 1'b0) begin
      failures++;
      $display("FAIL mul_wb: got early=%0d v=%b d=%0d rd=%0d e=%b want 0 1 42 5 0", early, wb_valid, wb_data, wb_rd_idx, wb_error);
    end
    release_wb();
    checks++;
    if (in_pulses - p0 != 1 || wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_done: got pulses=%0d v=%b ready=%b want 1 0 1", in_pulses - p0, wb_valid, issue_ready);
    end
  endtask

  // Covers both divide-by-zero and signed-overflow local results.
  task automatic test_local();
    logic [2:0]  f3s[4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as[4]  = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[4]  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
    bit ok;
    int p0;
    for (int i = 0; i < 4; i++) begin
      p0 = in_pulses;
      do_issue(mk_instr(7'b0000001, f3s[i], 5'd9, 7'b0110011), as[i], bs[i], ok);
      checks++;
      if (!ok || wb_valid !== 1'b1 || wb_data !== exps[i] || wb_error !== 1'b0 || wb_rd_idx !== 5'd9) begin
        failures++;
        $display("FAIL local_%0d: got v=%b d=%h e=%b rd=%0d want 1 %h 0 9", i, wb_valid, wb_data, wb_error, wb_rd_idx, exps[i]);
      end
      release_wb();
      checks++;
      if (in_pulses != p0) begin
        failures++;
        $display("FAIL local_nostart_%0d: got %0d mdu pulses want 0", i, in_pulses - p0);
      end
    end
  endtask

  task automatic test_illegal_stall();
    bit ok;
    int bad;
    int p0;
    p0 = in_pulses;
    bad = 0;
    do_issue(mk_instr(7'b0000000, 3'd0, 5'd3, 7'b0110011), 32'd1, 32'd2, ok);
    checks++;
    if (!ok || wb_valid !== 1'b1 || wb_error !== 1'b1 || wb_data !== 0 || wb_rd_idx !== 5'd3) begin
      failures++;
      $display("FAIL illegal_wb: got v=%b e=%b d=%h rd=%0d want 1 1 0 3", wb_valid, wb_error, wb_data, wb_rd_idx);
    end
    issue_valid = 1'b1;
    issue_instr = 32'h0262_82B3;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_valid !== 1'b1 || wb_error !== 1'b1 || wb_data !== 0 || wb_rd_idx !== 5'd3 || issue_ready !== 1'b0) bad++;
    end
    issue_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL illegal_stall: got %0d unstable cycles want 0", bad);
    end
    issue_valid = 1'b1;
    release_wb();
    issue_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || in_pulses != p0) begin
      failures++;
      $display("FAIL illegal_handoff: got v=%b ready=%b pulses=%0d want 0 1 0", wb_valid, issue_ready, in_pulses - p0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int bad;
    int c0;
    c0 = clr_pulses;
    bad = 0;
    do_issue(mk_instr(7'b0000001, 3'd1, 5'd12, 7'b0110011), 32'd3, 32'd4, ok);
    tick();
    for (int i = 0; i < 64; i++) begin
      if (wb_valid !== 1'b0 || mdu_clr !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL timeout_wait: got ok=%0b early_cycles=%0d want 1 0", ok, bad);
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_error !== 1'b1 || wb_data !== 0 || mdu_clr !== 1'b1) begin
      failures++;
      $display("FAIL timeout_resp: got v=%b e=%b d=%h clr=%b want 1 1 0 1", wb_valid, wb_error, wb_data, mdu_clr);
    end
    mdu_out_valid = 1'b1;
    mdu_rd = 32'hDEAD_BEEF;
    tick();
    mdu_out_valid = 1'b0;
    checks++;
    if (mdu_clr !== 1'b0 || wb_data !== 0 || wb_error !== 1'b1 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL timeout_late: got clr=%b d=%h e=%b v=%b want 0 0 1 1", mdu_clr, wb_data, wb_error, wb_valid);
    end
    release_wb();
    mdu_out_valid = 1'b1;
    tick();
    mdu_out_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || clr_pulses - c0 != 1) begin
      failures++;
      $display("FAIL timeout_idle: got v=%b ready=%b clr_pulses=%0d want 0 1 1", wb_valid, issue_ready, clr_pulses - c0);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int early;
    logic [31:0] instr;
    instr = mk_instr(7'b0000001, 3'd3, 5'd17, 7'b0110011);
    do_issue(instr, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (!ok || wb_valid !== 1'b0 || mdu_clr !== 1'b1 || issue_ready !== 1'b0 ||
        mdu_in_valid !== 1'b0 || mdu_rs1 !== 0 || mdu_funct3 !== 0 || wb_rd_idx !== 0) begin
      failures++;
      $display("FAIL midreset: got v=%b clr=%b ready=%b iv=%b rs1=%h f3=%b rd=%0d want 0 1 0 0 0 0 0",
               wb_valid, mdu_clr, issue_ready, mdu_in_valid, mdu_rs1, mdu_funct3, wb_rd_idx);
    end
    rst = 1'b1;
    tick();
    do_issue(instr, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
    respond(4, ref_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0, early);
    checks++;
    if (!ok || early != 0 || wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FFFE || wb_rd_idx !== 5'd17) begin
      failures++;
      $display("FAIL midreset_mulhu: got early=%0d v=%b d=%h rd=%0d want 0 1 fffffffe 17", early, wb_valid, wb_data, wb_rd_idx);
    end
    release_wb();
  endtask

  task automatic test_random();
    bit ok;
    int early;
    int p0;
    int hold;
    int bad;
    logic [6:0] f7;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic exp_e;
    logic err;
    bit illegal;
    bit loc;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: begin f7 = 7'b0000000; op = 7'b0110011; end
        1: begin f7 = 7'b0100001; op = 7'b0110011; end
        2: begin f7 = 7'b0000001; op = 7'b0010011; end
        default: begin f7 = 7'b0000001; op = 7'b0110011; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      a = pick();
      b = pick();
      illegal = (f7 != 7'b0000001) || (op != 7'b0110011);
      loc = !illegal && ref_local(f3, a, b);
      exp_q.push_back(illegal ? 32'h0 : ref_m(f3, a, b));
      exp_e = illegal;
      p0 = in_pulses;
      early = 0;
      do_issue(mk_instr(f7, f3, rd, op), a, b, ok);
      if (!illegal && !loc) begin
        checks++;
        if (!ok || mdu_in_valid !== 1'b1 || mdu_rs1 !== a || mdu_rs2 !== b || mdu_funct3 !== f3) begin
          failures++;
          $display("FAIL rand_issue_%0d: got iv=%b rs1=%h rs2=%h f3=%b want 1 %h %h %b", n, mdu_in_valid, mdu_rs1, mdu_rs2, mdu_funct3, a, b, f3);
        end
        err = 1'($urandom_range(0, 3) == 0);
        exp_e = err;
        respond($urandom_range(1, 8), exp_q[0], err, early);
      end
      exp_d = exp_q.pop_front();
      checks++;
      if (!ok || early != 0 || wb_valid !== 1'b1 || wb_data !== exp_d || wb_error !== exp_e ||
          wb_rd_idx !== rd || issue_ready !== 1'b0) begin
        failures++;
        $display("FAIL rand_wb_%0d: got early=%0d v=%b d=%h e=%b rd=%0d want 0 1 %h %b %0d", n, early, wb_valid, wb_data, wb_error, wb_rd_idx, exp_d, exp_e, rd);
      end
      hold = $urandom_range(0, 3);
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (wb_valid !== 1'b1 || wb_data !== exp_d || wb_error !== exp_e) bad++;
      end
      release_wb();
      checks++;
      if (bad != 0 || wb_valid !== 1'b0 || in_pulses - p0 != ((illegal || loc) ? 0 : 1)) begin
        failures++;
        $display("FAIL rand_done_%0d: got unstable=%0d v=%b pulses=%0d want 0 0 %0d", n, bad, wb_valid, in_pulses - p0, (illegal || loc) ? 0 : 1);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    issue_valid = 1'b0;
    issue_instr = '0;
    issue_rs1_val = '0;
    issue_rs2_val = '0;
    mdu_rd = '0;
    mdu_out_valid = 1'b0;
    mdu_in_error = 1'b0;
    wb_ready = 1'b0;
    test_reset();
    test_mul();
    test_local();
    test_illegal_stall();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32m_issue.md
Name: rv32m_issue

Overview:
- Issue/writeback sequencer directly upstream of the multicycle rv32m multiply/divide unit.
- Accepts one decoded R-type instruction with its operand values over a valid/ready handshake and checks that it belongs to the M extension.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally; otherwise drives rv32m and waits for its out_valid.
- Returns one result per instruction on a valid/ready writeback port, with timeout protection against a hung unit.

Parameters:
- TIMEOUT, 64, WAIT-state cycles before the op is aborted; minimum 2.
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  block can accept an instruction.
- issue_instr  in  32  raw instruction word.
- issue_rs1_val  in  32  rs1 register value.
- issue_rs2_val  in  32  rs2 register value.
- mdu_rs1  out  32  operand to rv32m rs1.
- mdu_rs2  out  32  operand to rv32m rs2.
- mdu_funct3  out  3  to rv32m funct3.
- mdu_in_valid  out  1  one-cycle start pulse to rv32m in_valid.
- mdu_clr  out  1  active-high clear to rv32m rst.
- mdu_rd  in  32  rv32m result.
- mdu_out_valid  in  1  rv32m result valid.
- mdu_in_error  in  1  rv32m error flag.
- wb_valid  out  1  result available.
- wb_ready  in  1  consumer accepts result.
- wb_rd_idx  out  5  destination register index.
- wb_data  out  32  result value.
- wb_error  out  1  illegal instruction, unit error or timeout.

Behaviour:
- Reset (rst=0 on a clock edge), taking priority over everything in any state, mid-op included:
  - state goes to IDLE and the WAIT counter clears to 0.
  - wb_valid, wb_error and mdu_in_valid go to 0.
  - wb_data, wb_rd_idx, mdu_rs1, mdu_rs2 and mdu_funct3 go to 0.
  - mdu_clr is 1 while rst=0.
- issue_ready = (state==IDLE) && rst.
- State IDLE:
  - An accept (issue_valid && issue_ready) latches the operands, funct3 = instr[14:12] and rd = instr[11:7].
  - Decode: legal M-op iff instr[6:0]=0110011 and instr[31:25]=0000001.
- Next state after an accept, evaluated in this priority order:
  1. Illegal: RESP, with wb_error=1 and wb_data=0.
  2. funct3[2]=1 and rs2==0: RESP. DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  3. DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: RESP. DIV gives 0x80000000; REM gives 0.
  4. Otherwise: ISSUE.
- rd==0 is executed normally; the consumer discards the result.
- State ISSUE (exactly one cycle):
  - mdu_in_valid=1.
  - Next state is WAIT; the counter clears.
- mdu_rs1, mdu_rs2 and mdu_funct3 are registered and held stable from the ISSUE cycle until the block leaves WAIT.
- State WAIT:
  - The counter increments each cycle.
  - mdu_out_valid=1: capture wb_data=mdu_rd and wb_error=mdu_in_error, then go to RESP. This takes priority over timeout in the same cycle.
  - Counter reaches TIMEOUT-1 with no out_valid: wb_data=0, wb_error=1, mdu_clr pulses for 1 cycle, then go to RESP.
- mdu_out_valid in any state other than WAIT is ignored.
- State RESP:
  - wb_valid=1, and wb_data, wb_rd_idx and wb_error are held stable.
  - wb_ready=1 (including in the first RESP cycle): go to IDLE, deassert wb_valid next cycle.
  - No back-to-back accept in the handoff cycle: issue_ready rises the cycle after RESP ends.
- Latency:
  - Local result: accept at cycle N gives wb_valid at N+1.
  - Unit result: accept at N, mdu_in_valid at N+1, out_valid first sampled at N+2; out_valid at cycle M gives wb_valid at M+1.
- Throughput: one instruction in flight; no queueing.
- Arithmetic: local results are pure constants/muxes. No arithmetic on 64-bit products here; they are rv32m's job.

Decomposition:
- rv32m_pkg:
  - funct3 constants MUL..REMU (000..111).
  - OPCODE_OP=7'b0110011, FUNCT7_MULDIV=7'b0000001.
  - INT_MIN=32'h80000000, NEG_ONE=32'hFFFFFFFF.
  - State encoding IDLE/ISSUE/WAIT/RESP.
- Sub-module rv32m_special_case:
  - Combinational.
  - Inputs funct3, rs1, rs2.
  - Outputs is_special and special_result.
  - Reusable by the bench as its golden model.

Test Plan:
- MUL x5 = 7*6 (instr 0x026282B3-style, rs1=7, rs2=6), model unit returns 42 after 10 cycles -> one mdu_in_valid pulse, mdu_funct3=000, wb_valid one cycle after out_valid, wb_data=42, wb_rd_idx=5, wb_error=0.
- DIVU rs1=0x1234, rs2=0 -> no mdu_in_valid, wb_valid at N+1, wb_data=0xFFFFFFFF; REMU same operands -> wb_data=0x1234.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> wb_data=0x80000000 locally; REM same -> wb_data=0.
- ADD instr (funct7=0000000) -> wb_error=1, wb_data=0, no mdu_in_valid; wb_ready held low 5 cycles -> wb outputs stable, issue_ready=0 throughout.
- Model unit never asserts out_valid, TIMEOUT=64 -> mdu_clr single pulse, wb_error=1 64 cycles after entering WAIT; late out_valid afterwards ignored.
- rst=0 asserted in WAIT -> next edge: IDLE, wb_valid=0, counter 0, mdu_clr=1; after release a new MULHU 0xFFFFFFFF*0xFFFFFFFF completes with wb_data=0xFFFFFFFE.
